// File: rtl/jk.sv
`default_nettype none
// ============================================================================
// Module   : jk
// Brief    : Bank of WIDTH independent positive-edge JK flip-flops with an
//            asynchronous active-high reset to RST_VAL.
// Revision : 1.0 - initial release
// ============================================================================
module jk #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_next;

  // Per-bit JK decode: hold, clear, set or toggle, each slice independent.
  always_comb begin
    q_next = q;
    for (int i = 0; i < WIDTH; i++) begin
      case ({j[i], k[i]})
        2'b01:   q_next[i] = 1'b0;
        2'b10:   q_next[i] = 1'b1;
        2'b11:   q_next[i] = ~q[i];
        default: q_next[i] = q[i];
      endcase
    end
  end

  // State register; reset acts immediately and overrides any clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= RST_VAL;
    end else begin
      q <= q_next;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_jk.sv
`default_nettype none
// ============================================================================
// Module   : tb_jk
// Brief    : Self-checking bench for jk: a WIDTH=1 flop, a WIDTH=4 bank with
//            RST_VAL=1010 and a WIDTH=8 bank driven with random J/K.
// Revision : 1.0 - initial release
// ============================================================================
module tb_jk;

  logic       clk = 1'b0;
  logic       run = 1'b0;
  logic       rst = 1'b0;
  logic [0:0] j1 = '0, k1 = '0, q1;
  logic [3:0] j4 = '0, k4 = '0, q4;
  logic [7:0] j8 = '0, k8 = '0, q8;

  localparam logic [3:0] RST4 = 4'b1010;

  int vectors     = 0;
  int miscompares = 0;

  // Scoreboard: expected value and tag pushed at drive time, popped at check.
  logic [63:0] exp_q[$];
  string       tag_q[$];

  // Reference model state for each DUT.
  logic [63:0] m1, m4, m8;

  jk #(.WIDTH(1)) u_jk1 (.clk(clk), .rst(rst), .j(j1), .k(k1), .q(q1));
  jk #(.WIDTH(4), .RST_VAL(RST4)) u_jk4 (.clk(clk), .rst(rst), .j(j4), .k(k4), .q(q4));
  jk #(.WIDTH(8)) u_jk8 (.clk(clk), .rst(rst), .j(j8), .k(k8), .q(q8));

  // Gated clock so the reset test can run with the clock stopped.
  always begin
    #5;
    if (run) clk = ~clk;
  end

  // Watchdog so the run can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "watchdog expired");
  end

  // JK characteristic equation: Q+ = J&~Q | ~K&Q.
  function automatic logic [63:0] jk_model(input logic [63:0] q, input logic [63:0] j,
                                           input logic [63:0] k);
    return (j & ~q) | (~k & q);
  endfunction

  task automatic push(input string tag, input logic [63:0] e);
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic check(input logic [63:0] obs);
    logic [63:0] e;
    string       t;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    vectors++;
    assert (obs === e) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", t, obs, e);
    end
  endtask

  // Check all three DUTs against the models without a clock edge.
  task automatic check_now(input string tag);
    push({tag, "_w1"}, m1);
    push({tag, "_w4"}, m4);
    push({tag, "_w8"}, m8);
    check({63'd0, q1});
    check({60'd0, q4});
    check({56'd0, q8});
  endtask

  // Advance one rising edge, update models, then check all DUTs.
  task automatic cycle(input string tag);
    if (rst) begin
      m1 = 64'd0;
      m4 = {60'd0, RST4};
      m8 = 64'd0;
    end else begin
      m1 = jk_model(m1, {63'd0, j1}, {63'd0, k1});
      m4 = jk_model(m4, {60'd0, j4}, {60'd0, k4});
      m8 = jk_model(m8, {56'd0, j8}, {56'd0, k8});
    end
    @(posedge clk);
    #1;
    check_now(tag);
    j8 = 8'($urandom);
    k8 = 8'($urandom);
  endtask

  initial begin
    // Async reset with clock stopped.
    j1 = 1'b1; k1 = 1'b0;
    j4 = 4'b0011; k4 = 4'b0101;
    #3;
    rst = 1'b1;
    #1;
    m1 = 64'd0; m4 = {60'd0, RST4}; m8 = 64'd0;
    check_now("async_rst");
    #4;
    rst = 1'b0;
    #2;
    check_now("rst_release_noclk");
    run = 1'b1;
    // First edge: q1 sets, q4 1010 -> 1011 (toggle/set/clear/hold).
    cycle("first_edge");

    // Clear then set.
    j1 = 1'b0; k1 = 1'b1; j4 = 4'b0000; k4 = 4'b1111;
    cycle("clear");
    j1 = 1'b1; k1 = 1'b0; j4 = 4'b1111; k4 = 4'b0000;
    cycle("set");

    // Toggle five edges: 0,1,0,1,0.
    j1 = 1'b1; k1 = 1'b1; j4 = 4'b0101; k4 = 4'b0101;
    for (int i = 0; i < 5; i++) cycle("toggle");

    // Hold from 0 then from 1.
    j1 = 1'b0; k1 = 1'b0; j4 = 4'b0000; k4 = 4'b0000;
    for (int i = 0; i < 3; i++) cycle("hold0");
    j1 = 1'b1; k1 = 1'b0;
    cycle("set_for_hold");
    j1 = 1'b0; k1 = 1'b0;
    for (int i = 0; i < 3; i++) cycle("hold1");

    // Glitch J/K between edges; restore before the next edge.
    #1;
    j1 = 1'b1; k1 = 1'b1; j4 = 4'b1111; k4 = 4'b1111;
    #2;
    check_now("glitch_mid");
    j1 = 1'b0; k1 = 1'b0; j4 = 4'b0000; k4 = 4'b0000;
    cycle("glitch_edge");

    // Reset mid-operation while toggling.
    j1 = 1'b1; k1 = 1'b1; j4 = 4'b1111; k4 = 4'b1111;
    cycle("pre_rst_toggle");
    #2;
    rst = 1'b1;
    #1;
    m1 = 64'd0; m4 = {60'd0, RST4}; m8 = 64'd0;
    check_now("mid_rst_async");
    for (int i = 0; i < 3; i++) cycle("rst_held");
    #3;
    rst = 1'b0;
    cycle("resume1");
    cycle("resume2");

    // Random J/K for all banks.
    for (int i = 0; i < 20; i++) begin
      j1 = 1'($urandom); k1 = 1'($urandom);
      j4 = 4'($urandom); k4 = 4'($urandom);
      cycle("random");
    end

    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: observed %0d left required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
